pool2_flatten_streamer: RTL
===========================

# pool2_flatten_streamer

Layout-converting stream buffer that sits between the second 2x2 max-pool stage and the dense classifier in the CIFAR-10 fixed-point inference pipeline. It accepts one pooled feature volume in channel-major order (channel, row, column), the order in which the max-pool stage produces its outputs. It then replays the volume in flatten order (row, column, channel) over a valid/ready stream. The block is the consuming end of the pooled-map interface: the max-pool stage writes the volume, and this block reads it back in the order the dense layer expects.

## Interface
- WIDTH, 8, pooled map width (columns)
- HEIGHT, 8, pooled map height (rows)
- CHANNELS, 32, number of feature maps
- DATA_W, 25, signed element width (the fixed-point pooled value, passed through unmodified)
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream element valid
- in_ready  output  1  block can accept an element
- in_data  input  DATA_W  signed pooled element, channel-major order
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  downstream accepts the element
- out_data  output  DATA_W  signed element, flatten order
- out_index  output  clog2(N)  flatten index k of the current out_data; N = WIDTH*HEIGHT*CHANNELS
- out_last  output  1  high with element k = N-1
- done  output  1  one-cycle pulse after the final output handshake

## Operation
- Storage: N x DATA_W buffer with synchronous read. With the defaults this is 2048 x 25.
- States: LOAD, STREAM, DONE.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready handshake writes in_data to address wa, then wa increments.
  - wa = c*H*W + y*W + x, i.e. sequential arrival order.
  - Writing address N-1 moves the block to STREAM, with in_ready=0 from the next cycle.
- STREAM:
  - Element k carries flatten index k = (y*W + x)*CHANNELS + c.
  - Element k is read from buffer address c*H*W + y*W + x.
  - Traversal uses nested counters: c innermost, then x, then y.
  - No multiply is allowed on the read path.
- Output handshake:
  - An element transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_index and out_last are held stable.
  - out_valid never drops without a handshake.
- The handshake on k = N-1, with out_last=1, moves the block to DONE.
- DONE: done=1 for exactly one cycle, then the block returns to LOAD with wa=0, ready for the next image.
- Data is passed bit-exact: no saturation and no sign change.
- Upstream back-pressure is ignored outside LOAD: in_valid is don't-care whenever in_ready=0.

## Timing
- Reset values, held every cycle rst=1:
  - state=LOAD and all counters 0.
  - in_ready=0, out_valid=0, out_data=0, out_index=0, out_last=0, done=0.
- in_ready rises the first cycle after rst deasserts.
- Input throughput: 1 element/cycle; a full load takes N handshake cycles.
- Load-to-stream latency:
  - Call the edge of the final input handshake E.
  - in_ready=0 from E+1.
  - The first read is issued in cycle E+1.
  - out_valid=1 with k=0 from E+2.
- Output throughput: 1 element/cycle with out_ready held high.
  - The next read address is issued in the same cycle as a handshake.
  - This gives no bubbles between consecutive elements.
- Last element: on the final handshake (k=N-1), out_valid falls next cycle and done=1 that same cycle.
  - in_ready=1 again the cycle after done.
- out_ready toggling: a stall of any length preserves the presented element; resumption transfers it on the first cycle with out_ready=1.
- Reset mid-LOAD or mid-STREAM:
  - The block returns to the reset state next edge.
  - Partial buffer contents are discarded; no done pulse.
- The same reset rule applies if rst coincides with the final handshake: reset wins and done stays 0.
- in_valid during STREAM/DONE: ignored, no buffer write.

## Test plan
- Reset then load, default parameters:
  - Load in_data = arrival index 0..2047.
  - Expect k=0 -> 0, k=1 -> 64, k=31 -> 1984, k=32 -> 1, k=2047 -> 2047.
  - out_last only at k=2047.
  - One done pulse, in_ready back to 1.
- Throughput, with in_valid and out_ready held high:
  - First out_valid exactly 2 cycles after the last input edge.
  - 2048 consecutive output handshakes with no gaps.
  - done 1 cycle after the last handshake.
- Back-pressure:
  - Randomise out_ready at 30% high.
  - out_data and out_index stay stable during every stall.
  - The sequence is identical to the first test.
- Signed pass-through:
  - Load -16777216 (min 25-bit), 16777215 and -1 at arrival indices 0, 1, 64.
  - Expect identical values at k = 0, 32, 1.
- Reset mid-operation:
  - Assert rst after 1000 inputs, and separately at k=500.
  - All outputs return to reset values next cycle, no done pulse.
  - A subsequent full load streams correctly.
- Small configuration W=2, H=2, C=3:
  - Load 0..11.
  - Output order 0,4,8,1,5,9,2,6,10,3,7,11.
  - Back-to-back second image works without reset.

Source files
------------

// File: rtl/pool2_flatten_streamer_if.sv
// pool2_flatten_streamer_if
//   Bundles the two streams of the pooled-map flatten buffer.
//   Input side : in_valid / in_ready / in_data  (channel-major arrival order)
//   Output side: out_valid / out_ready / out_data / out_index / out_last
//   Status     : done (one-cycle pulse after the final output handshake)
//   Modports:
//     slave  - the streamer block itself (consumes in_*, produces out_*)
//     master - the environment (max-pool producer plus dense consumer)
interface pool2_flatten_streamer_if #(
    parameter int DATA_W = 25,
    parameter int IDX_W  = 11
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic        [IDX_W-1:0]  out_index;
    logic                     out_last;
    logic                     done;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, done
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, done
    );
endinterface

// File: rtl/pool2_flatten_streamer.sv
// pool2_flatten_streamer
//   Buffers one pooled feature volume arriving in (channel, row, column)
//   order and replays it in flatten order (row, column, channel).
//   Ports:
//     clk  - single rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - pool2_flatten_streamer_if.slave
//            in_valid/in_ready/in_data  : volume load, one element per cycle
//            out_valid/out_ready/out_data/out_index/out_last : flattened replay
//            done : one-cycle pulse after the last output handshake
module pool2_flatten_streamer #(
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8,
    parameter int CHANNELS = 32,
    parameter int DATA_W   = 25
) (
    input logic                     clk,
    input logic                     rst,
    pool2_flatten_streamer_if.slave bus
);
    localparam int N  = WIDTH * HEIGHT * CHANNELS;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [AW-1:0] PLANE     = AW'(WIDTH * HEIGHT);
    localparam logic [CW-1:0] C_LAST    = CW'(CHANNELS - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        LOAD,
        STREAM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [N];

    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [AW-1:0] pix;
    logic [AW-1:0] issue_k;
    logic [CW-1:0] c;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [AW-1:0]     out_index_q;

    logic wr_en;
    logic rd_en;
    logic out_fire;
    logic last_fire;
    logic at_last;

    always_comb begin
        wr_en     = bus.in_valid && in_ready_q;
        out_fire  = out_valid_q && bus.out_ready;
        last_fire = out_fire && out_last_q;
        // A read refills the output register whenever it is empty or its
        // element is leaving, except after the final element was issued.
        rd_en     = (state == STREAM) && (!out_valid_q || (bus.out_ready && !out_last_q));
        at_last   = (c == C_LAST) && (x == X_LAST) && (y == Y_LAST);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (wr_en && (wa == LAST_ADDR)) state_next = STREAM;
            STREAM:  if (last_fire) state_next = DONE;
            DONE:    state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // in_ready is registered so it stays low through reset and drops the
    // cycle after the final write.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_next == LOAD);
        end
    end

    // ---------------- load side ----------------
    always_ff @(posedge clk) begin
        if (rst || (state == DONE)) begin
            wa <= '0;
        end else if (wr_en) begin
            wa <= wa + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wa] <= bus.in_data;
        end
    end

    // ---------------- read address generation ----------------
    // pix tracks y*WIDTH+x; stepping c adds one plane, wrapping c restarts
    // from the next pixel, so the address needs no multiplier.
    always_ff @(posedge clk) begin
        if (rst || (state != STREAM)) begin
            c       <= '0;
            x       <= '0;
            y       <= '0;
            pix     <= '0;
            ra      <= '0;
            issue_k <= '0;
        end else if (rd_en) begin
            issue_k <= issue_k + AW'(1);
            if (c == C_LAST) begin
                c   <= '0;
                pix <= pix + AW'(1);
                ra  <= pix + AW'(1);
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end else begin
                c  <= c + CW'(1);
                ra <= ra + PLANE;
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else if (rd_en) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem[ra];
            out_index_q <= issue_k;
            out_last_q  <= at_last;
        end else if (last_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = (state == DONE);

endmodule
